// File: rtl/exec_ctl_pkg.sv
// Shared types and constants for the execution sequencer.
package exec_ctl_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StCstep = 3'd1,
      StIstep = 3'd2,
      StRun   = 3'd3,
      StBreak = 3'd4
   } ctl_state_e;

   localparam logic [1:0] MODE_CYC   = 2'b00;
   localparam logic [1:0] MODE_INSTR = 2'b01;
   localparam logic [1:0] MODE_RUN   = 2'b10;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 and flags the terminal count, restartable via clear_i.
module tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] Last = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == Last);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/exec_controller.sv
// Execution sequencer issuing one-cycle processor enable pulses (step, istep, run).
// Breakpoint compare and BREAK state are built only when EXECCTL_BREAKPOINT_EN is defined.
module exec_controller
   import exec_ctl_pkg::*;
#(
   parameter int unsigned RUN_DIV     = 25000000,
   parameter logic [3:0]  FETCH_STATE = 4'h1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        go_i,
   input  logic [1:0]  mode_i,
   input  logic [6:0]  break_pc_i,
   input  logic        break_arm_i,
   input  logic [6:0]  pc_i,
   input  logic [3:0]  state_i,
   output logic        proc_en_o,
   output logic [2:0]  ctl_state_o,
   output logic        running_o,
   output logic        break_hit_o,
   output logic [15:0] cycle_count_o,
   output logic [15:0] instr_count_o
);

   ctl_state_e  state_q, state_d;
   logic        proc_en_q, proc_en_d;
   logic        armed_q, armed_d;
   logic        running_q, running_d;
   logic [15:0] cycle_q, cycle_d;
   logic [15:0] instr_q, instr_d;
   logic        tick, clear, is_fetch, brk_match;

   assign is_fetch = (state_i == FETCH_STATE);

`ifdef EXECCTL_BREAKPOINT_EN
   logic break_hit_q;

   assign brk_match   = break_arm_i && (pc_i == break_pc_i) && is_fetch;
   assign break_hit_o = break_hit_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         break_hit_q <= 1'b0;
      end else begin
         break_hit_q <= (state_d == StBreak);
      end
   end
`else
   logic unused_brk;

   assign unused_brk  = ^{break_arm_i, break_pc_i};
   assign brk_match   = 1'b0;
   assign break_hit_o = 1'b0;
`endif

   tick_gen #(
      .DIV(RUN_DIV)
   ) u_tick_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clear_i(clear),
      .tick_o (tick)
   );

   always_comb begin
      state_d   = state_q;
      proc_en_d = 1'b0;
      armed_d   = armed_q;
      clear     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (go_i) begin
               clear   = 1'b1;
               armed_d = 1'b0;
               case (mode_i)
                  MODE_INSTR: state_d = StIstep;
                  MODE_RUN:   state_d = StRun;
                  default:    state_d = StCstep;
               endcase
            end
         end
         StCstep: begin
            proc_en_d = 1'b1;
            state_d   = StIdle;
         end
         StIstep: begin
            // Go wins over a coincident tick
            if (go_i) begin
               state_d = StIdle;
            end else if (tick) begin
               if (armed_q && is_fetch) begin
                  state_d = StIdle;
               end else begin
                  proc_en_d = 1'b1;
                  armed_d   = 1'b1;
               end
            end
         end
         StRun: begin
            if (go_i) begin
               state_d = StIdle;
            end else if (tick) begin
               if (brk_match && armed_q) begin
                  state_d = StBreak;
               end else begin
                  proc_en_d = 1'b1;
                  armed_d   = 1'b1;
               end
            end
         end
         StBreak: begin
            if (go_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      running_d = (state_d == StIstep) || (state_d == StRun);
      cycle_d   = cycle_q;
      instr_d   = instr_q;
      if (proc_en_d) begin
         cycle_d = cycle_q + 16'd1;
         if (is_fetch) begin
            instr_d = instr_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         proc_en_q <= 1'b0;
         armed_q   <= 1'b0;
         running_q <= 1'b0;
         cycle_q   <= '0;
         instr_q   <= '0;
      end else begin
         state_q   <= state_d;
         proc_en_q <= proc_en_d;
         armed_q   <= armed_d;
         running_q <= running_d;
         cycle_q   <= cycle_d;
         instr_q   <= instr_d;
      end
   end

   assign proc_en_o     = proc_en_q;
   assign ctl_state_o   = state_q;
   assign running_o     = running_q;
   assign cycle_count_o = cycle_q;
   assign instr_count_o = instr_q;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller with a stub processor and a pulse scoreboard.
module tb_exec_controller;
   import exec_ctl_pkg::*;

   localparam int unsigned RUN_DIV = 4;
   localparam logic [3:0]  FETCH   = 4'h1;

   logic        clk = 1'b0;
   logic        rst, go, break_arm;
   logic [1:0]  mode;
   logic [6:0]  break_pc, pc;
   logic [3:0]  st;
   logic        proc_en_o, running_o, break_hit_o;
   logic [2:0]  ctl_state_o;
   logic [15:0] cycle_count_o, instr_count_o;

   always #5 clk = ~clk;

   exec_controller #(
      .RUN_DIV    (RUN_DIV),
      .FETCH_STATE(FETCH)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .go_i         (go),
      .mode_i       (mode),
      .break_pc_i   (break_pc),
      .break_arm_i  (break_arm),
      .pc_i         (pc),
      .state_i      (st),
      .proc_en_o    (proc_en_o),
      .ctl_state_o  (ctl_state_o),
      .running_o    (running_o),
      .break_hit_o  (break_hit_o),
      .cycle_count_o(cycle_count_o),
      .instr_count_o(instr_count_o)
   );

   typedef struct {
      int unsigned cyc;
      logic [15:0] cnt;
      logic [15:0] icnt;
   } pulse_t;

   typedef struct {
      logic [1:0] mode;
      logic [2:0] st;
      logic       run;
      bit         pulse;
   } vec_t;

   pulse_t      sb[$];
   vec_t        vt[4];
   int          n_tests = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;
   int unsigned wrap_pulses = 0;
   bit          sb_on = 1'b1;
   bit          freeze = 1'b0;
   bit          prev_en = 1'b0;
   logic [15:0] mdl_cnt, mdl_icnt;
   logic [3:0]  mdl_st;
   logic [6:0]  mdl_pc;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Expected pulse: counters as the DUT should show them when the pulse is visible
   function automatic void push_pulse(int unsigned at);
      if (mdl_st == FETCH) mdl_icnt++;
      mdl_cnt++;
      sb.push_back(pulse_t'{at, mdl_cnt, mdl_icnt});
      if (!freeze) begin
         if (mdl_st == FETCH) mdl_pc = mdl_pc + 7'd1;
         mdl_st = (mdl_st == 4'd3) ? 4'd1 : mdl_st + 4'd1;
      end
   endfunction

   task automatic tick();
      pulse_t p;
      @(posedge clk);
      #1;
      cyc++;
      // Stub processor captures on the edge that ends the enable cycle
      if (prev_en && !freeze) begin
         if (st == FETCH) pc = pc + 7'd1;
         st = (st == 4'd3) ? 4'd1 : st + 4'd1;
      end
      prev_en = proc_en_o;
      if (proc_en_o) begin
         if (!sb_on) begin
            wrap_pulses++;
         end else if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: got pulse, expected none (cycle %0d)", cyc);
         end else begin
            p = sb.pop_front();
            chk("pulse_cycle", cyc, p.cyc);
            chk("pulse_cyclecount", 32'(cycle_count_o), 32'(p.cnt));
            chk("pulse_instrcount", 32'(instr_count_o), 32'(p.icnt));
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      go  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      prev_en = 1'b0;
      st = FETCH;
      pc = 7'd0;
      mdl_st = FETCH;
      mdl_pc = 7'd0;
      mdl_cnt = 16'd0;
      mdl_icnt = 16'd0;
      sb.delete();
      tick();
   endtask

   task automatic go_strobe(input logic [1:0] m);
      mode = m;
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned c0, e, stop_at;
      rst = 1'b1;
      go = 1'b0;
      mode = 2'b00;
      break_pc = 7'd0;
      break_arm = 1'b0;
      pc = 7'd0;
      st = FETCH;

      // Reset state
      do_reset();
      chk("rst_state", 32'(ctl_state_o), 32'(StIdle));
      chk("rst_proc_en", 32'(proc_en_o), 32'd0);
      chk("rst_running", 32'(running_o), 32'd0);
      chk("rst_break_hit", 32'(break_hit_o), 32'd0);
      chk("rst_cycle_count", 32'(cycle_count_o), 32'd0);
      chk("rst_instr_count", 32'(instr_count_o), 32'd0);

      // Mode decode table
      vt[0] = '{2'b00, 3'(StCstep), 1'b0, 1'b1};
      vt[1] = '{2'b11, 3'(StCstep), 1'b0, 1'b1};
      vt[2] = '{2'b01, 3'(StIstep), 1'b1, 1'b0};
      vt[3] = '{2'b10, 3'(StRun),   1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         c0 = cyc;
         go_strobe(vt[i].mode);
         if (vt[i].pulse) push_pulse(c0 + 2);
         chk("decode_state", 32'(ctl_state_o), 32'(vt[i].st));
         chk("decode_running", 32'(running_o), 32'(vt[i].run));
         if (!vt[i].pulse) go_strobe(vt[i].mode);
         tick();
         tick();
         chk("decode_idle", 32'(ctl_state_o), 32'(StIdle));
         chk("decode_running_off", 32'(running_o), 32'd0);
      end
      chk("decode_cycle_count", 32'(cycle_count_o), 32'(mdl_cnt));
      chk("decode_sb_empty", sb.size(), 32'd0);

      // Cycle step: three strobes 10 cycles apart
      do_reset();
      for (int i = 0; i < 3; i++) begin
         c0 = cyc;
         go_strobe(MODE_CYC);
         push_pulse(c0 + 2);
         tick();
         chk("cstep_idle", 32'(ctl_state_o), 32'(StIdle));
         repeat (8) tick();
      end
      chk("cstep_cycle_count", 32'(cycle_count_o), 32'd3);
      chk("cstep_sb_empty", sb.size(), 32'd0);

      // Instruction step from a fetch state
      do_reset();
      go_strobe(MODE_INSTR);
      e = cyc;
      push_pulse(e + 4);
      push_pulse(e + 8);
      push_pulse(e + 12);
      for (int i = 0; i < 40 && ctl_state_o != 3'(StIdle); i++) tick();
      chk("istep_stop_cycle", cyc, e + 16);
      chk("istep_state", 32'(ctl_state_o), 32'(StIdle));
      chk("istep_instr_count", 32'(instr_count_o), 32'd1);
      chk("istep_cycle_count", 32'(cycle_count_o), 32'd3);
      chk("istep_sb_empty", sb.size(), 32'd0);

      // Run with breakpoint at PC 5
      do_reset();
      break_pc = 7'h05;
      break_arm = 1'b1;
      go_strobe(MODE_RUN);
      e = cyc;
`ifdef EXECCTL_BREAKPOINT_EN
      stop_at = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1 && mdl_st == FETCH && mdl_pc == 7'd5) begin
            stop_at = e + 4 * k;
            break;
         end
         push_pulse(e + 4 * k);
      end
      for (int i = 0; i < 200 && ctl_state_o == 3'(StRun); i++) tick();
      chk("break_cycle", cyc, stop_at);
      chk("break_state", 32'(ctl_state_o), 32'(StBreak));
      chk("break_hit", 32'(break_hit_o), 32'd1);
      chk("break_running", 32'(running_o), 32'd0);
      chk("break_cycle_count", 32'(cycle_count_o), 32'd15);
      chk("break_instr_count", 32'(instr_count_o), 32'd5);
      repeat (6) tick();
      chk("break_hold", 32'(ctl_state_o), 32'(StBreak));
      go_strobe(MODE_RUN);
      chk("break_exit_state", 32'(ctl_state_o), 32'(StIdle));
      chk("break_exit_hit", 32'(break_hit_o), 32'd0);
`else
      stop_at = e + 66;
      for (int k = 1; k <= 16; k++) push_pulse(e + 4 * k);
      while (cyc < stop_at) tick();
      chk("nobrk_state", 32'(ctl_state_o), 32'(StRun));
      chk("nobrk_hit", 32'(break_hit_o), 32'd0);
      go_strobe(MODE_RUN);
      chk("nobrk_exit_state", 32'(ctl_state_o), 32'(StIdle));
      chk("nobrk_cycle_count", 32'(cycle_count_o), 32'd16);
`endif
      repeat (6) tick();
      chk("run_sb_empty", sb.size(), 32'd0);

      // Go coincident with a matching tick: Go wins
      do_reset();
      freeze = 1'b1;
      pc = 7'h05;
      mdl_pc = 7'h05;
      break_pc = 7'h05;
      break_arm = 1'b1;
      go_strobe(MODE_RUN);
      e = cyc;
      push_pulse(e + 4);
      while (cyc < e + 7) tick();
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("prio_state", 32'(ctl_state_o), 32'(StIdle));
      chk("prio_break_hit", 32'(break_hit_o), 32'd0);
      chk("prio_running", 32'(running_o), 32'd0);
      repeat (6) tick();
      chk("prio_cycle_count", 32'(cycle_count_o), 32'd1);
      chk("prio_sb_empty", sb.size(), 32'd0);
      freeze = 1'b0;
      break_arm = 1'b0;

      // Asynchronous reset in the middle of a pulse
      do_reset();
      go_strobe(MODE_RUN);
      e = cyc;
      push_pulse(e + 4);
      while (cyc < e + 4) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_proc_en", 32'(proc_en_o), 32'd0);
      chk("arst_cycle_count", 32'(cycle_count_o), 32'd0);
      chk("arst_instr_count", 32'(instr_count_o), 32'd0);
      chk("arst_state", 32'(ctl_state_o), 32'(StIdle));
      chk("arst_running", 32'(running_o), 32'd0);
      prev_en = 1'b0;
      rst = 1'b0;
      repeat (12) tick();
      chk("arst_after_state", 32'(ctl_state_o), 32'(StIdle));
      chk("arst_after_count", 32'(cycle_count_o), 32'd0);
      chk("arst_sb_empty", sb.size(), 32'd0);

      // Counter wrap: Go held high gives a cycle step every two cycles
      do_reset();
      sb_on = 1'b0;
      wrap_pulses = 0;
      mode = MODE_CYC;
      go = 1'b1;
      for (int i = 0; i < 140000 && wrap_pulses < 65537; i++) tick();
      go = 1'b0;
      tick();
      tick();
      chk("wrap_pulses", wrap_pulses, 32'd65537);
      chk("wrap_cycle_count", 32'(cycle_count_o), 32'h0001);
      chk("wrap_instr_count", 32'(instr_count_o), 32'd21846);
      chk("wrap_state", 32'(ctl_state_o), 32'(StIdle));
      sb_on = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_controller.md
# exec_controller

Execution sequencer for the simple processor. Instead of clocking the processor directly from a debounced key, the processor runs on the system clock and is advanced only by a one-cycle enable pulse from this block. It supports single-cycle step, single-instruction step, free run at a prescaled rate, and a PC breakpoint. It also keeps cycle and instruction counters for the display mux.

## Interface
- RUN_DIV, 25000000: system-clock cycles between enable opportunities in RUN and ISTEP; legal range ≥ 2.
- FETCH_STATE, 4'h1: processor state code for instruction fetch.
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high; one clock domain only.
- Go  in  1  one-cycle strobe from the key filter: start, step or stop.
- Mode  in  2  00 cycle step, 01 instruction step, 10 run, 11 treated as 00; sampled only when Go is seen in IDLE.
- BreakPC  in  7  breakpoint address.
- BreakArm  in  1  breakpoint enable switch.
- PC_In  in  7  processor PC.
- State_In  in  4  processor FSM state.
- ProcEn  out  1  registered one-cycle processor clock-enable pulse.
- CtlState  out  3  encoded controller state.
- Running  out  1  high in RUN or ISTEP.
- BreakHit  out  1  high in BREAK.
- CycleCount  out  16  number of ProcEn pulses issued.
- InstrCount  out  16  number of ProcEn pulses issued while State_In == FETCH_STATE.

## Operation
- States: IDLE, CSTEP, ISTEP, RUN, BREAK. All outputs are registered.
- Reset values: state IDLE, ProcEn 0, counters 0, BreakHit 0, Running 0, prescaler 0, `armed` 0.
- IDLE + Go: the Mode value selects the next state.
  - Mode 00 or 11 → CSTEP.
  - Mode 01 → ISTEP.
  - Mode 10 → RUN.
- Entering ISTEP or RUN clears the prescaler and `armed`.
- CSTEP: issue exactly one ProcEn pulse, then return to IDLE. Go arriving in CSTEP is ignored.
- The prescaler counts 0 to RUN_DIV-1. `tick` is asserted when the count equals RUN_DIV-1; the count then wraps to 0.
- RUN, on each tick, checks these in order:
  1. If BreakArm, `armed`, and PC_In == BreakPC, and State_In == FETCH_STATE: go to BREAK with no pulse.
  2. Otherwise: pulse ProcEn and set `armed`.
- ISTEP, on each tick:
  - If `armed` and State_In == FETCH_STATE: go to IDLE with no pulse.
  - Otherwise: pulse ProcEn and set `armed`.
- Go in RUN or ISTEP → IDLE, and no pulse is issued that cycle. Go takes priority over a simultaneous tick or breakpoint match.
- BREAK: ProcEn stays 0 and BreakHit = 1. Go → IDLE, which clears BreakHit.
- `armed` guarantees at least one pulse before a stop condition, so a run started at BreakPC, or an ISTEP started at fetch, makes progress.
- Counters increment by 1 in the cycle ProcEn is driven high and wrap from FFFF to 0000. InstrCount evaluates State_In in that same decision cycle.
- Reset mid-operation: immediate return to IDLE, ProcEn is dropped asynchronously, and counters are cleared.

## Timing
- Go accepted at edge N → ProcEn high from edge N+1 to N+2. For CSTEP, the state is back in IDLE after N+2.
- The processor captures on the edge that ends the ProcEn cycle. PC_In and State_In are valid by the next decision, guaranteed by RUN_DIV ≥ 2.
- The first pulse in RUN or ISTEP occurs RUN_DIV cycles after entry. Pulses are then spaced exactly RUN_DIV cycles apart.
- Break detection and stop have 1-cycle latency from the tick or Go to the state change.

## Configuration
- EXECCTL_BREAKPOINT_EN defined: the breakpoint compare and the BREAK state are built as described above.
- EXECCTL_BREAKPOINT_EN undefined:
  - the compare logic is removed;
  - BreakPC and BreakArm are ignored;
  - BreakHit is tied to 0;
  - BREAK is unreachable, and RUN stops only on Go or Reset.

## Structure
- Package exec_ctl_pkg holds:
  - the controller state enum (IDLE=0, CSTEP=1, ISTEP=2, RUN=3, BREAK=4);
  - mode constants: MODE_CYC, MODE_INSTR, MODE_RUN.
- Sub-module tick_gen (parameter DIV; ports Clk, Reset, Clear, Tick) implements the prescaler with a $clog2(DIV)-bit counter.

## Test plan
All scenarios use RUN_DIV=4 and FETCH_STATE=1.
- Cycle step: Mode=00, three Go strobes spaced 10 cycles apart → exactly 3 single-cycle ProcEn pulses; CycleCount=3; state returns to IDLE each time.
- Instruction step: Mode=01, stub processor FSM cycles states 1→2→3→1 per pulse, starting at state 1, then Go → 3 pulses 4 cycles apart, then stop in IDLE; InstrCount=1.
- Run and breakpoint: Mode=10, BreakArm=1, BreakPC=7'h05, stub PC increments on each fetch → BREAK reached with PC_In=5 and no pulse on the matching tick; BreakHit=1; Go → IDLE with BreakHit=0.
- Priority: in RUN, assert Go on the same cycle as a matching tick → state IDLE, BreakHit stays 0, no pulse.
- Reset mid-run: Reset asserted between ticks → ProcEn=0 and counters 0 immediately; after release, state is IDLE with no pulses until Go.
- Wrap: preload CycleCount near FFFF via 65535 CSTEP pulses, then 2 more → CycleCount=0001.
